// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
`timescale 1ns/1ps
package div_arb_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    // Quotient reported for divide-by-zero; truncated to the instance width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
`timescale 1ns/1ps
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
        if (req != 2'b00) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between two requesters with round-robin arbitration,
// local divide-by-zero handling and a bounded wait for the divider's done pulse.
`timescale 1ns/1ps
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DIV_WIDTH,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_dividend,
    input  logic [2*WIDTH-1:0]   req_divisor,
    output logic [1:0]           rsp_valid,
    output logic [WIDTH-1:0]     rsp_quotient,
    output logic [WIDTH-1:0]     rsp_remainder,
    output logic                 rsp_err,
    output logic                 div_start,
    output logic [WIDTH-1:0]     div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    input  logic                 div_done,
    input  logic [WIDTH-1:0]     div_quotient,
    input  logic [WIDTH-1:0]     div_remainder,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;
    logic               r_div_start;
    logic [1:0]         r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_quotient;
    logic [WIDTH-1:0]   r_rsp_remainder;
    logic               r_rsp_err;
    logic               r_busy;

    logic [1:0]         w_gnt;
    logic               w_gnt_idx;
    logic               w_accept;
    logic               w_rsp_idx;
    logic [WIDTH-1:0]   w_sel_dividend;
    logic [WIDTH-1:0]   w_sel_divisor;
    logic [WIDTH-1:0]   w_rsp_quotient;
    logic [WIDTH-1:0]   w_rsp_remainder;
    logic               w_rsp_err;

    rr_arb2 u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .gnt        (w_gnt),
        .gnt_idx    (w_gnt_idx)
    );

    assign w_sel_dividend = w_gnt_idx ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
    assign w_sel_divisor  = w_gnt_idx ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];

    // Accept handshake must complete in the IDLE cycle itself, so ready is decoded from state.
    assign req_ready     = (sys_rst_n && (r_state == IDLE)) ? w_gnt : 2'b00;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_err       = r_rsp_err;
    assign div_start     = r_div_start;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign busy          = r_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_rsp_idx       = r_gnt;
        w_rsp_quotient  = r_rsp_quotient;
        w_rsp_remainder = r_rsp_remainder;
        w_rsp_err       = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    w_accept  = 1'b1;
                    w_rsp_idx = w_gnt_idx;
                    if (w_sel_divisor == '0) begin
                        w_next_state    = RESP;
                        w_rsp_quotient  = WIDTH'(DIV0_QUOTIENT);
                        w_rsp_remainder = w_sel_dividend;
                        w_rsp_err       = 1'b1;
                    end else begin
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                // A done pulse on the final counted cycle still counts as success.
                if (div_done) begin
                    w_next_state    = RESP;
                    w_rsp_quotient  = div_quotient;
                    w_rsp_remainder = div_remainder;
                    w_rsp_err       = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_next_state    = RESP;
                    w_rsp_quotient  = '0;
                    w_rsp_remainder = '0;
                    w_rsp_err       = 1'b1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Counter starts at zero in ISSUE so the abort lands TIMEOUT+1 cycles after div_start.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_grant    <= 1'b1;
            r_gnt           <= 1'b0;
            r_cnt           <= '0;
            r_div_dividend  <= '0;
            r_div_divisor   <= '0;
            r_div_start     <= 1'b0;
            r_rsp_valid     <= 2'b00;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt          <= w_gnt_idx;
                r_div_dividend <= w_sel_dividend;
                r_div_divisor  <= w_sel_divisor;
                r_cnt          <= '0;
            end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == RESP) begin
                r_last_grant <= r_gnt;
            end
            r_rsp_quotient  <= w_rsp_quotient;
            r_rsp_remainder <= w_rsp_remainder;
            r_rsp_err       <= w_rsp_err;
            r_div_start     <= (w_next_state == ISSUE);
            r_rsp_valid     <= (w_next_state == RESP) ? (w_rsp_idx ? 2'b10 : 2'b01) : 2'b00;
            r_busy          <= (w_next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a response table plus timeout, reset-abort and spurious-done sequences.
`timescale 1ns/1ps
module tb_div_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 63;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_dividend;
    logic [2*W-1:0]  req_divisor;
    logic [1:0]      rsp_valid;
    logic [W-1:0]    rsp_quotient;
    logic [W-1:0]    rsp_remainder;
    logic            rsp_err;
    logic            div_start;
    logic [W-1:0]    div_dividend;
    logic [W-1:0]    div_divisor;
    logic            div_done;
    logic [W-1:0]    div_quotient;
    logic [W-1:0]    div_remainder;
    logic            busy;

    div_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Divider model: done LAT cycles after div_start, or never when m_hang is set.
    localparam int unsigned LAT = 18;
    logic         m_hang;
    logic         m_spur;
    logic         m_busy;
    logic         m_done;
    int unsigned  m_cnt;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    assign div_done = m_done | m_spur;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_busy        <= 1'b0;
            m_done        <= 1'b0;
            m_cnt         <= 0;
            m_a           <= '0;
            m_b           <= '0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else begin
            m_done <= 1'b0;
            if (div_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_a    <= div_dividend;
                m_b    <= div_divisor;
            end else if (m_busy && !m_hang) begin
                if (m_cnt == LAT - 1) begin
                    m_done        <= 1'b1;
                    m_busy        <= 1'b0;
                    div_quotient  <= m_a / m_b;
                    div_remainder <= m_a % m_b;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // Cycle stamps and pulse counters, sampled just after the falling edge.
    int cyc = 0;
    int n_start = 0;
    int n_ready = 0;
    int n_rsp = 0;
    int start_cyc = 0;
    int acc_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always begin
        @(negedge sys_clk);
        #1;
        if (div_start) begin
            n_start   = n_start + 1;
            start_cyc = cyc;
        end
        if (req_ready != 2'b00) begin
            n_ready = n_ready + 1;
            acc_cyc = cyc;
        end
        if (rsp_valid != 2'b00) n_rsp = n_rsp + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        @(negedge sys_clk);
        if (idx) begin
            req_dividend[2*W-1:W] = a;
            req_divisor[2*W-1:W]  = b;
        end else begin
            req_dividend[W-1:0] = a;
            req_divisor[W-1:0]  = b;
        end
        req_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (req_ready[idx]) ok = 1'b1;
            else @(negedge sys_clk);
        end
        check("accept", 32'(ok), 32'd1);
        @(posedge sys_clk);
        #1;
        req_valid = 2'b00;
    endtask

    task automatic wait_rsp(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge sys_clk);
            if (rsp_valid != 2'b00) ok = 1'b1;
        end
        check("rsp_seen", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [1:0]   mask;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   vld;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
        int           starts;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        logic ok;
        int   snap_start;
        int   snap_ready;
        int   snap_rsp;

        vecs[0] = '{2'b11, 16'd1000, 16'd10, 16'd65535, 16'd256, 2'b01, 16'd100,   16'd0,    1'b0, 20, 1};
        vecs[1] = '{2'b11, 16'd1000, 16'd10, 16'd65535, 16'd256, 2'b10, 16'd255,   16'd255,  1'b0, 20, 1};
        vecs[2] = '{2'b11, 16'd1000, 16'd10, 16'd65535, 16'd256, 2'b01, 16'd100,   16'd0,    1'b0, 20, 1};
        vecs[3] = '{2'b11, 16'd1000, 16'd10, 16'd65535, 16'd256, 2'b10, 16'd255,   16'd255,  1'b0, 20, 1};
        vecs[4] = '{2'b01, 16'd100,  16'd7,  16'd0,     16'd0,   2'b01, 16'd14,    16'd2,    1'b0, 20, 1};
        vecs[5] = '{2'b10, 16'd0,    16'd0,  16'd1234,  16'd0,   2'b10, 16'hFFFF,  16'd1234, 1'b1, 1,  0};
        vecs[6] = '{2'b10, 16'd0,    16'd0,  16'd40000, 16'd3,   2'b10, 16'd13333, 16'd1,    1'b0, 20, 1};
        vecs[7] = '{2'b01, 16'd0,    16'd9,  16'd0,     16'd0,   2'b01, 16'd0,     16'd0,    1'b0, 20, 1};
        vecs[8] = '{2'b11, 16'd5,    16'd0,  16'd17,    16'd5,   2'b10, 16'd3,     16'd2,    1'b0, 20, 1};
        vecs[9] = '{2'b11, 16'd5,    16'd0,  16'd17,    16'd5,   2'b01, 16'hFFFF,  16'd5,    1'b1, 1,  0};

        m_hang       = 1'b0;
        m_spur       = 1'b0;
        sys_rst_n    = 1'b0;
        req_valid    = vecs[0].mask;
        req_dividend = {vecs[0].a1, vecs[0].a0};
        req_divisor  = {vecs[0].b1, vecs[0].b0};

        // Reset state, with both requesters already valid.
        repeat (3) @(negedge sys_clk);
        check("rst_ctrl", 32'({req_ready, rsp_valid, rsp_err, div_start, busy}), 32'd0);
        check("rst_rsp", {rsp_quotient, rsp_remainder}, 32'd0);
        check("rst_ops", {div_dividend, div_divisor}, 32'd0);
        snap_start = n_start;
        snap_ready = n_ready;
        sys_rst_n  = 1'b1;

        // Response table: inputs for the next entry are driven in the RESP cycle of the previous one.
        for (int i = 0; i < NV; i++) begin
            req_valid    = vecs[i].mask;
            req_dividend = {vecs[i].a1, vecs[i].a0};
            req_divisor  = {vecs[i].b1, vecs[i].b0};
            wait_rsp(100, ok);
            check($sformatf("v%0d_vld", i), 32'(rsp_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d_q", i), 32'(rsp_quotient), 32'(vecs[i].q));
            check($sformatf("v%0d_r", i), 32'(rsp_remainder), 32'(vecs[i].r));
            check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
            check($sformatf("v%0d_lat", i), 32'(cyc - acc_cyc), 32'(vecs[i].lat));
            check($sformatf("v%0d_starts", i), 32'(n_start - snap_start), 32'(vecs[i].starts));
            check($sformatf("v%0d_readys", i), 32'(n_ready - snap_ready), 32'd1);
            snap_start = n_start;
            snap_ready = n_ready;
        end
        req_valid = 2'b00;

        // Response bus holds the last result while idle.
        repeat (5) @(negedge sys_clk);
        check("hold_vld", 32'(rsp_valid), 32'd0);
        check("hold_q", 32'(rsp_quotient), 32'hFFFF);
        check("hold_r", 32'(rsp_remainder), 32'd5);
        check("hold_err", 32'(rsp_err), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);

        // Divider never answers: abort TIMEOUT+1 cycles after div_start.
        m_hang = 1'b1;
        send(1'b0, 16'd50, 16'd5);
        wait_rsp(200, ok);
        check("tmo_vld", 32'(rsp_valid), 32'd1);
        check("tmo_err", 32'(rsp_err), 32'd1);
        check("tmo_qr", {rsp_quotient, rsp_remainder}, 32'd0);
        check("tmo_lat", 32'(cyc - start_cyc), 32'(TMO + 1));
        check("tmo_busy_resp", 32'(busy), 32'd1);
        @(negedge sys_clk);
        check("tmo_busy_after", 32'(busy), 32'd0);
        m_hang = 1'b0;

        // Reset in the middle of WAIT aborts the job silently.
        send(1'b1, 16'd500, 16'd3);
        repeat (5) @(negedge sys_clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        snap_rsp  = n_rsp;
        sys_rst_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({req_ready, rsp_valid, rsp_err, div_start, busy}), 32'd0);
        check("abort_rsp", {rsp_quotient, rsp_remainder}, 32'd0);
        check("abort_ops", {div_dividend, div_divisor}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("abort_no_rsp", 32'(n_rsp - snap_rsp), 32'd0);
        send(1'b0, 16'd9, 16'd4);
        wait_rsp(60, ok);
        check("post_rst_vld", 32'(rsp_valid), 32'd1);
        check("post_rst_qr", {rsp_quotient, rsp_remainder}, {16'd2, 16'd1});
        check("post_rst_err", 32'(rsp_err), 32'd0);

        // Spurious done while idle must not produce a response.
        repeat (3) @(negedge sys_clk);
        snap_rsp = n_rsp;
        m_spur   = 1'b1;
        @(negedge sys_clk);
        m_spur   = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("spur_no_rsp", 32'(n_rsp - snap_rsp), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        send(1'b0, 16'd7, 16'd7);
        wait_rsp(60, ok);
        check("spur_job_vld", 32'(rsp_valid), 32'd1);
        check("spur_job_qr", {rsp_quotient, rsp_remainder}, {16'd1, 16'd0});
        check("spur_job_err", 32'(rsp_err), 32'd0);

        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one sequential WIDTH-bit divider unit between two requesters, e.g. the UART command decoder and the display/key path.
- Arbitrates with a round-robin policy and accepts operands through a valid/ready handshake.
- Sequences the divider with a one-cycle start pulse and waits for its done pulse.
- Returns quotient and remainder on a shared response bus with a per-requester valid pulse. Divide-by-zero and divider hangs are handled locally, so a requester never deadlocks.

Parameters:
- WIDTH, 16, operand/result width in bits.
- TIMEOUT, 63, maximum cycles to wait in WAIT for div_done before aborting with error (must be ≥ WIDTH+2).

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- req_valid  in  2  bit i: requester i presents operands.
- req_ready  out  2  bit i: one-cycle accept pulse to requester i.
- req_dividend  in  2*WIDTH  packed {req1, req0} dividends.
- req_divisor  in  2*WIDTH  packed {req1, req0} divisors.
- rsp_valid  out  2  bit i: one-cycle result pulse to requester i.
- rsp_quotient  out  WIDTH  shared quotient bus, valid when any rsp_valid bit is high.
- rsp_remainder  out  WIDTH  shared remainder bus.
- rsp_err  out  1  result is an error (divide-by-zero or timeout), qualified by rsp_valid.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  WIDTH  divider operand, held stable from ISSUE until leaving WAIT.
- div_divisor  out  WIDTH  divider operand, held the same way.
- div_done  in  1  divider completion pulse.
- div_quotient  in  WIDTH  divider result, sampled when div_done=1.
- div_remainder  in  WIDTH  divider result, sampled when div_done=1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. All outputs reset to 0, state=IDLE, timeout counter=0, last_grant=1 (requester 0 wins first).
- FSM IDLE: if any req_valid bit is set, the round-robin picker chooses g (the requester that is not last_grant wins a tie). In the same cycle: req_ready[g]=1, latch operands, record g.
  - Latched divisor==0 → RESP with err=1, quotient=all ones, remainder=dividend.
  - Otherwise → ISSUE.
- FSM ISSUE: div_start=1 for exactly one cycle; clear timeout counter → WAIT.
- FSM WAIT: counter increments every cycle.
  - div_done=1 → latch div_quotient/div_remainder, err=0 → RESP.
  - Else if counter==TIMEOUT → err=1, quotient=0, remainder=0 → RESP.
  - div_done wins if both occur in the same cycle.
- FSM RESP: rsp_valid[g]=1 for one cycle with the latched results and err; last_grant←g → IDLE.
- Between responses, rsp_quotient/rsp_remainder/rsp_err hold their last values.
- Latency, accept at cycle T:
  - Normal: div_start at T+1; div_done at cycle k gives rsp_valid at k+1.
  - Divide-by-zero: rsp_valid at T+1 and div_start is never asserted.
- Throughput: the next accept can occur in the cycle after RESP, i.e. back-to-back requests are spaced by one IDLE cycle.
- Requester rules:
  - Hold req_valid and operands until req_ready. Dropping valid before ready is legal and has no effect.
  - A request from the granted requester seen during its own RESP is not accepted until IDLE.
- div_done in IDLE, ISSUE or RESP is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No response is issued for the aborted request; the requester re-requests.
- Arithmetic: no width growth. quotient/remainder are passed through unchanged; the timeout counter is $clog2(TIMEOUT+1) bits.

Decomposition:
- Package div_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - DIV_WIDTH default 16.
  - Constant DIV0_QUOTIENT = all ones.
- Sub-module rr_arb2: a 2-way round-robin picker. Inputs: req[1:0] and last_grant. Outputs: gnt onehot and gnt_idx. Purely combinational.
- The FSM, operand/result registers and timeout counter live in div_arbiter.

Test Plan:
- Only req0 with 100/7, divider model 18-cycle latency → one div_start pulse; rsp_valid=2'b01, q=14, r=2, err=0; req_ready[0] pulses exactly once.
- Both valid from reset (req0 1000/10, req1 65535/256), held asserted → req0 served first (q=100, r=0), then req1 (q=255, r=255). Four back-to-back rounds alternate 0,1,0,1.
- req1 1234/0 → rsp_valid=2'b10 at accept+1; err=1, q=0xFFFF, r=1234; div_start never asserted.
- Divider model never returns done, req0 50/5 → rsp_valid[0] with err=1, q=0, r=0 exactly TIMEOUT+1 cycles after div_start; busy drops the next cycle.
- sys_rst_n pulsed low mid-WAIT → all outputs 0 immediately and no rsp_valid for the aborted job. A subsequent req0 9/4 returns q=2, r=1 normally.
- Spurious div_done in IDLE, then a legitimate job 7/7 → no rsp_valid from the spurious pulse; the job returns q=1, r=0.
